// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the two-requester logic-unit arbiter.
//   state_t : controller states (IDLE accepts a request, EXEC evaluates,
//             RESP holds the result until the owner takes it).
//   OP_*    : opcode encoding, bit0 = s0, bit1 = s1 of the logic unit.
package alu_share_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_XNOR = 2'b11;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response channels of both requesters.
//   reqN_valid/ready/op/a/b : request channel of requester N (master drives valid+payload)
//   rspN_valid/ready/data   : response channel of requester N (slave drives valid+data)
// master = requester side, slave = arbiter side.
interface alu_share_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [WIDTH-1:0] rsp0_data;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [WIDTH-1:0] rsp1_data;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    output req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    input  req0_ready, rsp0_valid, rsp0_data,
    input  req1_ready, rsp1_valid, rsp1_data
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, rsp0_ready,
    input  req1_valid, req1_op, req1_a, req1_b, rsp1_ready,
    output req0_ready, rsp0_valid, rsp0_data,
    output req1_ready, rsp1_valid, rsp1_data
  );
endinterface

// File: rtl/alu_share_arbiter_logic_unit4.sv
// logic_unit4: combinational WIDTH-bit four-function logic unit.
//   s0, s1 : function select ({s1,s0}: 00 AND, 01 OR, 10 XOR, 11 XNOR)
//   a, b   : operands
//   y      : result
module logic_unit4
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             s0,
  input  logic             s1,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [1:0] sel;
  assign sel = {s1, s0};

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign y[gi] = (sel == OP_AND) ? (a[gi] & b[gi]) :
                   (sel == OP_OR)  ? (a[gi] | b[gi]) :
                   (sel == OP_XOR) ? (a[gi] ^ b[gi]) :
                                     ~(a[gi] ^ b[gi]);
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one logic_unit4 between two requesters.
// A round-robin grant accepts one request in IDLE, the operands are
// evaluated for one cycle in EXEC and the result is held in RESP until the
// owner accepts it. Only one operation is in flight.
//   clk, rst  : clock, asynchronous active-high reset
//   bus       : request/response channels (slave side)
//   busy      : controller is not in IDLE
//   grant_id  : owner of the current or most recent operation
//   op_count  : completed operations, wraps
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  alu_share_arbiter_if.slave bus,
  output logic               busy,
  output logic               grant_id,
  output logic [CNT_W-1:0]   op_count
);

  state_t             state_reg, state_next;
  logic               last_grant_reg;
  logic               owner_reg;
  logic [1:0]         op_reg;
  logic [WIDTH-1:0]   a_reg, b_reg, result_reg;
  logic [CNT_W-1:0]   count_reg;

  logic               grant_valid;
  logic               grant_sel;
  logic               req_fire;
  logic               rsp_fire;
  logic [WIDTH-1:0]   lu_y;

  // Round-robin: on a tie the requester that did not win last time goes.
  always_comb begin
    grant_valid = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) grant_sel = ~last_grant_reg;
    else                                  grant_sel = bus.req1_valid;
  end

  always_comb begin
    state_next     = state_reg;
    req_fire       = 1'b0;
    rsp_fire       = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    bus.rsp0_data  = '0;
    bus.rsp1_data  = '0;
    case (state_reg)
      IDLE: begin
        // Ready is only ever raised towards a valid requester, so a grant
        // is always a handshake. Gated by rst so ready reads 0 in reset.
        if (grant_valid && !rst) begin
          bus.req0_ready = ~grant_sel;
          bus.req1_ready = grant_sel;
          req_fire       = 1'b1;
          state_next     = EXEC;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (owner_reg) begin
          bus.rsp1_valid = 1'b1;
          bus.rsp1_data  = result_reg;
          rsp_fire       = bus.rsp1_ready;
        end else begin
          bus.rsp0_valid = 1'b1;
          bus.rsp0_data  = result_reg;
          rsp_fire       = bus.rsp0_ready;
        end
        if (rsp_fire) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      owner_reg      <= 1'b0;
      op_reg         <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      result_reg     <= '0;
      count_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (req_fire) begin
        owner_reg <= grant_sel;
        op_reg    <= grant_sel ? bus.req1_op : bus.req0_op;
        a_reg     <= grant_sel ? bus.req1_a  : bus.req0_a;
        b_reg     <= grant_sel ? bus.req1_b  : bus.req0_b;
      end
      if (state_reg == EXEC) result_reg <= lu_y;
      if (rsp_fire) begin
        last_grant_reg <= owner_reg;
        count_reg      <= count_reg + 1'b1;
      end
    end
  end

  logic_unit4 #(.WIDTH(WIDTH)) u_logic_unit (
    .s0 (op_reg[0]),
    .s1 (op_reg[1]),
    .a  (a_reg),
    .b  (b_reg),
    .y  (lu_y)
  );

  assign busy     = (state_reg != IDLE);
  assign grant_id = owner_reg;
  assign op_count = count_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       busy;
  logic       grant_id;
  logic [7:0] op_count;

  int total = 0;
  int bad   = 0;

  alu_share_arbiter_if #(.WIDTH(4)) bus ();

  alu_share_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, actual, expected, $time);
    end
  endtask

  // Reference function from the opcode table.
  function automatic logic [3:0] ref_op(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  // Transaction-level model: one pending operation with a due cycle.
  int         cyc = 0;
  logic       m_pending = 1'b0;
  logic       m_owner = 1'b0;
  logic       m_last = 1'b1;
  logic [3:0] m_data = '0;
  int         m_due = 0;
  int         m_acc = 0;
  logic [7:0] m_count = '0;
  logic       seen_valid = 1'b0;
  int         first_valid = 0;

  // Observed completions (DUT values), for the directed checks.
  int         done_owner[$];
  int         done_data[$];
  int         done_cyc[$];
  int         done_lat[$];
  int         done_gid[$];

  always @(negedge clk) begin
    logic exp_r0, exp_r1, winner, rsp_on, owner_rdy;
    cyc++;
    if (rst) begin
      chk("rst_busy", busy, 0);
      chk("rst_req0_ready", bus.req0_ready, 0);
      chk("rst_req1_ready", bus.req1_ready, 0);
      chk("rst_rsp0_valid", bus.rsp0_valid, 0);
      chk("rst_rsp1_valid", bus.rsp1_valid, 0);
      chk("rst_grant_id", grant_id, 0);
      chk("rst_op_count", op_count, 0);
      m_pending  = 1'b0;
      m_owner    = 1'b0;
      m_last     = 1'b1;
      m_count    = '0;
      seen_valid = 1'b0;
    end else begin
      exp_r0 = 1'b0;
      exp_r1 = 1'b0;
      winner = bus.req1_valid;
      if (bus.req0_valid && bus.req1_valid) winner = ~m_last;
      if (!m_pending && (bus.req0_valid || bus.req1_valid)) begin
        exp_r0 = ~winner;
        exp_r1 = winner;
      end
      rsp_on = m_pending && (cyc >= m_due);
      chk("req0_ready", bus.req0_ready, exp_r0);
      chk("req1_ready", bus.req1_ready, exp_r1);
      chk("rsp0_valid", bus.rsp0_valid, rsp_on && !m_owner);
      chk("rsp1_valid", bus.rsp1_valid, rsp_on && m_owner);
      chk("rsp0_data", bus.rsp0_data, (rsp_on && !m_owner) ? m_data : 4'd0);
      chk("rsp1_data", bus.rsp1_data, (rsp_on && m_owner) ? m_data : 4'd0);
      chk("busy", busy, m_pending);
      chk("grant_id", grant_id, m_owner);
      chk("op_count", op_count, m_count);

      if (m_pending && !seen_valid && (m_owner ? bus.rsp1_valid : bus.rsp0_valid)) begin
        seen_valid  = 1'b1;
        first_valid = cyc;
      end
      owner_rdy = m_owner ? bus.rsp1_ready : bus.rsp0_ready;
      if (rsp_on && owner_rdy) begin
        done_owner.push_back(m_owner);
        done_data.push_back(m_owner ? bus.rsp1_data : bus.rsp0_data);
        done_cyc.push_back(cyc);
        done_lat.push_back(seen_valid ? first_valid - m_acc : -1);
        done_gid.push_back(grant_id);
        $display("txn %0d owner=%0d data=%b lat=%0d cyc=%0d", done_owner.size(), m_owner,
                 m_owner ? bus.rsp1_data : bus.rsp0_data, seen_valid ? first_valid - m_acc : -1, cyc);
        m_pending  = 1'b0;
        m_last     = m_owner;
        m_count    = m_count + 8'd1;
        seen_valid = 1'b0;
      end else if (!m_pending && ((exp_r0 && bus.req0_valid) || (exp_r1 && bus.req1_valid))) begin
        m_pending = 1'b1;
        m_owner   = winner;
        m_data    = winner ? ref_op(bus.req1_op, bus.req1_a, bus.req1_b)
                           : ref_op(bus.req0_op, bus.req0_a, bus.req0_b);
        m_acc     = cyc;
        m_due     = cyc + 2;
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send0(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    bit got = 0;
    bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (bus.req0_ready) got = 1;
    end
    if (got) begin @(posedge clk); #1; end
    else chk("send0_accept", 0, 1);
    bus.req0_valid = 1'b0;
  endtask

  task automatic send1(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
    bit got = 0;
    bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (bus.req1_ready) got = 1;
    end
    if (got) begin @(posedge clk); #1; end
    else chk("send1_accept", 0, 1);
    bus.req1_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_owner.size() < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_done", done_owner.size(), target);
  endtask

  initial begin
    int base, raise_cyc;
    logic [3:0] exp_t1 [4];
    exp_t1[0] = 4'b1000; exp_t1[1] = 4'b1110; exp_t1[2] = 4'b0110; exp_t1[3] = 4'b1001;

    bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
    bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
    bus.rsp0_ready = 0; bus.rsp1_ready = 0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_busy", busy, 0);
    chk("reset_grant_id", grant_id, 0);
    chk("reset_op_count", op_count, 0);

    // Single requester, all opcodes.
    bus.rsp0_ready = 1'b1;
    base = done_owner.size();
    for (int k = 0; k < 4; k++) begin
      send0(2'(k), 4'b1100, 4'b1010);
      wait_done(base + k + 1, 20);
    end
    for (int k = 0; k < 4; k++) begin
      chk("t1_data", done_data[base+k], exp_t1[k]);
      chk("t1_owner", done_owner[base+k], 0);
      chk("t1_latency", done_lat[base+k], 2);
    end
    chk("t1_op_count", op_count, 4);

    // Tie right after reset: requester 0 first, then requester 1.
    do_reset();
    bus.rsp1_ready = 1'b1;
    base = done_owner.size();
    fork
      send0(2'b00, 4'b0011, 4'b0101);
      send1(2'b01, 4'b0011, 4'b0101);
    join
    wait_done(base + 2, 20);
    chk("t2_owner0", done_owner[base], 0);
    chk("t2_owner1", done_owner[base+1], 1);
    chk("t2_data0", done_data[base], 4'b0001);
    chk("t2_data1", done_data[base+1], 4'b0111);
    chk("t2_gid0", done_gid[base], 0);
    chk("t2_gid1", done_gid[base+1], 1);

    // Fairness with both requesters held valid.
    do_reset();
    base = done_owner.size();
    bus.req0_op = 2'b00; bus.req0_a = 4'b1100; bus.req0_b = 4'b1010;
    bus.req1_op = 2'b01; bus.req1_a = 4'b1100; bus.req1_b = 4'b1010;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    wait_done(base + 6, 40);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("t3_owner", done_owner[base+k], k % 2);
      chk("t3_data", done_data[base+k], (k % 2) ? 4'b1110 : 4'b1000);
      if (k > 0) chk("t3_spacing", done_cyc[base+k] - done_cyc[base+k-1], 3);
    end
    chk("t3_op_count", op_count, 6);

    // Backpressure on requester 0 with requester 1 waiting.
    bus.rsp0_ready = 1'b0;
    base = done_owner.size();
    send0(2'b10, 4'b1111, 4'b0101);
    fork
      send1(2'b11, 4'b0000, 4'b0000);
    join_none
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t4_rsp0_valid", bus.rsp0_valid, 1);
      chk("t4_rsp0_data", bus.rsp0_data, 4'b1010);
      chk("t4_busy", busy, 1);
      chk("t4_req1_ready", bus.req1_ready, 0);
    end
    @(posedge clk); #1;
    bus.rsp0_ready = 1'b1;
    raise_cyc = cyc;
    wait_done(base + 1, 10);
    chk("t4_done_cycle", done_cyc[base], raise_cyc + 1);
    chk("t4_data0", done_data[base], 4'b1010);
    wait_done(base + 2, 20);
    chk("t4_owner1", done_owner[base+1], 1);
    chk("t4_data1", done_data[base+1], 4'b1111);
    chk("t4_op_count", op_count, 8);

    // Reset during EXEC aborts the operation.
    base = done_owner.size();
    send0(2'b01, 4'b1000, 4'b0100);
    chk("t5_busy_exec", busy, 1);
    rst = 1'b1;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_rsp0_valid", bus.rsp0_valid, 0);
    chk("t5_rsp0_data", bus.rsp0_data, 0);
    chk("t5_grant_id", grant_id, 0);
    chk("t5_op_count", op_count, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("t5_aborted", done_owner.size(), base);
    send0(2'b01, 4'b0001, 4'b0010);
    wait_done(base + 1, 20);
    chk("t5_data", done_data[base], 4'b0011);
    chk("t5_op_count_after", op_count, 1);

    // Counter wrap.
    do_reset();
    base = done_owner.size();
    bus.req0_op = 2'b00; bus.req0_a = 4'b1111; bus.req0_b = 4'b1111;
    bus.req0_valid = 1'b1;
    wait_done(base + 255, 900);
    chk("t6_op_count_255", op_count, 255);
    wait_done(base + 256, 10);
    bus.req0_valid = 1'b0;
    chk("t6_op_count_wrap", op_count, 0);
    chk("t6_data", done_data[base+255], 4'b1111);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Shares one 4-function logic unit (AND/OR/XOR/XNOR) between two requesters. Each requester gets a valid/ready request channel and a valid/ready response channel. A 3-state controller picks a requester round-robin, registers its operands, drives the unit's select lines for one cycle and holds the registered result until the owner accepts it. One operation is in flight at a time.

Parameters:
WIDTH, 4, operand/result width in bits.
CNT_W, 8, width of the completed-operation counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
req0_valid  in  1  requester 0 presents an operation.
req0_ready  out  1  requester 0's operation is accepted this cycle.
req0_op  in  2  requester 0 opcode: bit0 = s0, bit1 = s1.
req0_a, req0_b  in  WIDTH  requester 0 operands.
req1_valid, req1_ready, req1_op, req1_a, req1_b: same as above, for requester 1.
rsp0_valid  out  1  result for requester 0 is available.
rsp0_ready  in  1  requester 0 takes the result.
rsp0_data  out  WIDTH  result for requester 0.
rsp1_valid, rsp1_ready, rsp1_data: same as above, for requester 1.
busy  out  1  high in any state other than IDLE.
grant_id  out  1  owner of the current or last operation.
op_count  out  CNT_W  number of completed operations; wraps.

Behaviour:
- Reset (asynchronous, on rst high):
  - state = IDLE, last_grant = 1 so requester 0 wins the first tie.
  - Operand, op and result registers cleared.
  - All valid/ready outputs 0, busy 0, grant_id 0, op_count 0.
- Opcode map: 00 → A&B, 01 → A|B, 10 → A^B, 11 → ~(A^B).
- IDLE:
  - Grant selection, combinational from valids:
    - only one requester valid → that requester;
    - both valid → the one not equal to last_grant;
    - none valid → no grant.
  - reqN_ready = 1 only for the granted requester, and only in IDLE.
  - Handshake (valid & ready) captures op/a/b and sets owner = N, grant_id = N; next state EXEC.
  - The non-granted requester's ready stays 0; it must hold valid and its payload stable.
- EXEC (exactly 1 cycle):
  - Registered op drives s0/s1 of the logic unit; its output is latched into the result register.
  - Next state RESP.
- RESP:
  - rsp{owner}_valid = 1 and rsp{owner}_data = result, both held stable until rsp{owner}_ready.
  - On handshake: last_grant = owner, op_count += 1 (wraps from 2^CNT_W-1 to 0), next state IDLE.
  - The other response channel stays valid = 0.
  - reqN_ready = 0 for both requesters throughout RESP.
- Latency and throughput:
  - Request accepted at edge T → rsp_valid high from T+2.
  - With rsp_ready tied high, one operation completes every 3 cycles.
- rsp_data of a non-owner channel reads 0.
- rsp_ready asserted while the matching rsp_valid is 0 is ignored.
- Reset during EXEC or RESP aborts the operation: the result is discarded, op_count is not incremented, and the owner must re-request.
- A request whose valid drops before a handshake is silently withdrawn; no state change.

Decomposition:
- Shared package:
  - state encoding IDLE/EXEC/RESP;
  - opcode constants OP_AND = 2'b00, OP_OR = 2'b01, OP_XOR = 2'b10, OP_XNOR = 2'b11.
- One sub-module: logic_unit4, a combinational WIDTH-bit function unit selected by s0/s1, instantiated once.
- The FSM, round-robin pointer and counter live in the top module.

Test Plan:
- Single requester, all opcodes: A=1100, B=1010, req0 only, op 00/01/10/11 → rsp0_data 1000/1110/0110/1001; each rsp0_valid 2 cycles after accept; op_count 4.
- Tie after reset: both valid in the same cycle, req1 op 01, A=0011, B=0101 → req0 granted first; req1 granted on the next IDLE and returns 0111 on rsp1 only; grant_id sequence 0, 1.
- Fairness: both held valid for 6 operations, rsp_ready tied high → grants alternate 0,1,0,1,0,1; op_count 6; one completion per 3 cycles.
- Backpressure: rsp0_ready low for 5 cycles → rsp0_valid/data stable, busy = 1, req1_ready stays 0; result completes on the cycle rsp0_ready rises.
- Reset mid-op: assert rst during EXEC → all outputs 0 immediately; next request is accepted normally; op_count unchanged by the aborted operation.
- Counter wrap: preload 255 completions (CNT_W = 8), one more → op_count 0.
